vid_out_framer: RTL

VID_OUT_FRAMER -- requirements
Module: vid_out_framer

---
 rtl/vof_pkg.sv | 23 ++
 rtl/vof_fifo.sv | 52 +++++
 rtl/vid_out_framer.sv | 113 +++++++++++
 3 files changed

// File: rtl/vof_pkg.sv
// Shared types and constants for the video output framer.
// Entry layout is {sol, eol, data}; the line counter is 11 bits wide.
package vof_pkg;

  localparam int DW_DEF    = 16;
  localparam int DEPTH_DEF = 16;
  localparam int LCW       = 11;

  typedef struct packed {
    logic              sol;
    logic              eol;
    logic [DW_DEF-1:0] data;
  } vof_entry_t;

  function automatic logic [LCW-1:0] sat_inc(input logic [LCW-1:0] v);
    if (v == {LCW{1'b1}}) begin
      return v;
    end else begin
      return v + {{(LCW-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/vof_fifo.sv
// Synchronous FIFO with full/empty flags and a head word read from storage registers.
// The head reads as zero while empty so the framer outputs are clean after reset.
module vof_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  // The extra pointer bit tells a full FIFO from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? {W{1'b0}} : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= {(AW+1){1'b0}};
      rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/vid_out_framer.sv
// Frames a strobed pixel stream into sol/eol-tagged words behind a FIFO.
// Define VOF_LEN_CHECK_EN to enable the per-line length check (len_err).
module vid_out_framer
  import vof_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic           clk_100m,
  input  logic           rst_n,
  input  logic           vid_in,
  input  logic [DW-1:0]  data_in,
  input  logic [LCW-1:0] line_len,
  input  logic           err_clr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic           out_sol,
  output logic           out_eol,
  output logic           ovf_err,
  output logic           len_err
);

  logic          vid_prev;
  logic          hold_valid;
  logic          hold_sol;
  logic [DW-1:0] hold_data;
  logic [DW+1:0] head;
  logic          full;
  logic          empty;
  logic          ovf_set;

  // vid_prev clears on reset, so the first strobe after reset always opens a line.
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      vid_prev   <= 1'b0;
      hold_valid <= 1'b0;
      hold_sol   <= 1'b0;
      hold_data  <= {DW{1'b0}};
    end else begin
      vid_prev   <= vid_in;
      hold_valid <= vid_in;
      if (vid_in) begin
        hold_sol  <= !vid_prev;
        hold_data <= data_in;
      end
    end
  end

  // The held pixel is the last of its line when the strobe has just dropped.
  vof_fifo #(
    .W     (DW + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk_100m),
    .rst_n     (rst_n),
    .push      (hold_valid),
    .push_data ({hold_sol, !vid_in, hold_data}),
    .pop       (out_ready),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign out_valid                    = !empty;
  assign {out_sol, out_eol, out_data} = head;
  assign ovf_set                      = hold_valid && full && !out_ready;

  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
    end else if (ovf_set) begin
      ovf_err <= 1'b1;
    end else if (err_clr) begin
      ovf_err <= 1'b0;
    end
  end

`ifdef VOF_LEN_CHECK_EN
  logic [LCW-1:0] line_cnt;
  logic           len_set;

  // Counts captures, including pixels later dropped on a full FIFO.
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      line_cnt <= {LCW{1'b0}};
    end else if (vid_in) begin
      if (!vid_prev) begin
        line_cnt <= {{(LCW-1){1'b0}}, 1'b1};
      end else begin
        line_cnt <= sat_inc(line_cnt);
      end
    end
  end

  assign len_set = hold_valid && !vid_in && (line_cnt != line_len);

  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      len_err <= 1'b0;
    end else if (len_set) begin
      len_err <= 1'b1;
    end else if (err_clr) begin
      len_err <= 1'b0;
    end
  end
`else
  logic [LCW-1:0] unused_line_len;
  assign unused_line_len = line_len;
  assign len_err         = 1'b0;
`endif

endmodule
